// File: rtl/tdm_demux_ctrl.sv
// tdm_demux_ctrl
// Frame-aligned slot sequencer for an 8-slot bit-serial TDM link.
// The block hunts for a frame-sync marker and then counts bits and slots.
// It assembles each W-bit slot word MSB first and presents it as a parallel
// word with a one-hot per-channel strobe. Sync is checked on every frame
// boundary. Sync seen anywhere else re-aligns the frame. A missing sync at a
// frame boundary drops the lock and returns the block to hunting.
module tdm_demux_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         in_bit,
    input  logic         frame_sync,
    input  logic [7:0]   chan_en,
    output logic [2:0]   s,
    output logic [W-1:0] out_data,
    output logic [7:0]   out_valid,
    output logic [2:0]   out_chan,
    output logic         locked,
    output logic         frame_done,
    output logic         sync_err
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
    localparam logic [CW-1:0] ONE_BIT  = CW'(1);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   bit_cnt_q;
    logic [2:0]      s_q;
    logic [W-1:0]    sh_q;
    logic [W-1:0]    out_data_q;
    logic [7:0]      out_valid_q;
    logic [2:0]      out_chan_q;
    logic            locked_q;
    logic            frame_done_q;
    logic            sync_err_q;

    logic [W-1:0]    sh_d;
    logic            at_frame_start;
    logic            at_last_bit;
    logic [7:0]      strobe_d;

    // One-hot strobe for a completed slot, gated by that channel's enable.
    function automatic logic [7:0] slot_strobe(input logic [2:0] slot,
                                               input logic [7:0] en);
        logic [7:0] hot;
        hot = 8'd1 << slot;
        return hot & en;
    endfunction

    // Shift candidate and frame-position decodes for the current valid bit.
    always_comb begin
        sh_d           = {sh_q[W-2:0], in_bit};
        at_frame_start = (s_q == 3'd0) && (bit_cnt_q == '0);
        at_last_bit    = (bit_cnt_q == LAST_BIT);
        strobe_d       = slot_strobe(s_q, chan_en);
    end

    // HUNT/LOCK sequencer with registered word, strobe and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            s_q          <= 3'd0;
            sh_q         <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 8'd0;
            out_chan_q   <= 3'd0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            // Strobes last one cycle; they are only re-armed by a valid bit.
            out_valid_q  <= 8'd0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;

            if (in_valid) begin
                case (state_q)
                    HUNT: begin
                        // Only a sync-marked bit is accepted, as slot 0 bit 0.
                        if (frame_sync) begin
                            sh_q      <= sh_d;
                            bit_cnt_q <= ONE_BIT;
                            s_q       <= 3'd0;
                            state_q   <= LOCK;
                            locked_q  <= 1'b1;
                        end
                    end

                    LOCK: begin
                        if (frame_sync && !at_frame_start) begin
                            // Misplaced sync wins over word completion: drop
                            // the partial word and restart the frame here.
                            sync_err_q <= 1'b1;
                            sh_q       <= sh_d;
                            bit_cnt_q  <= ONE_BIT;
                            s_q        <= 3'd0;
                        end else if (!frame_sync && at_frame_start) begin
                            // Expected sync absent: discard the bit, lose lock.
                            sync_err_q <= 1'b1;
                            bit_cnt_q  <= '0;
                            s_q        <= 3'd0;
                            state_q    <= HUNT;
                            locked_q   <= 1'b0;
                        end else begin
                            sh_q <= sh_d;
                            if (at_last_bit) begin
                                out_data_q   <= sh_d;
                                out_chan_q   <= s_q;
                                out_valid_q  <= strobe_d;
                                frame_done_q <= (s_q == 3'd7);
                                bit_cnt_q    <= '0;
                                s_q          <= s_q + 3'd1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + ONE_BIT;
                            end
                        end
                    end

                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s          = s_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_chan   = out_chan_q;
    assign locked     = locked_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_ctrl.sv
// tb_tdm_demux_ctrl
// Directed and randomized bench for tdm_demux_ctrl.
// A frame-position model is kept in the bench. Every DUT output is compared
// against it after each clock.
module tb_tdm_demux_ctrl;

    localparam int W = 8;
    localparam int FRAME = 8 * W;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_bit;
    logic         frame_sync;
    logic [7:0]   chan_en;
    logic [2:0]   s;
    logic [W-1:0] out_data;
    logic [7:0]   out_valid;
    logic [2:0]   out_chan;
    logic         locked;
    logic         frame_done;
    logic         sync_err;

    tdm_demux_ctrl #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .frame_sync (frame_sync),
        .chan_en    (chan_en),
        .s          (s),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_chan   (out_chan),
        .locked     (locked),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: locked flag, position within the 8*W-bit frame,
    // and the last W bits received.
    bit           m_lock;
    int           m_pos;
    logic [W-1:0] m_acc;

    logic [2:0]   exp_s;
    logic [W-1:0] exp_data;
    logic [7:0]   exp_valid;
    logic [2:0]   exp_chan;
    logic         exp_locked;
    logic         exp_fd;
    logic         exp_err;

    int cyc;
    int n_strobe;
    int n_fd;
    int n_err;
    bit spacing_on;
    int last_strobe_cyc;

    logic [W-1:0] frame_w [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_lock     = 1'b0;
        m_pos      = 0;
        m_acc      = '0;
        exp_s      = 3'd0;
        exp_data   = '0;
        exp_valid  = 8'd0;
        exp_chan   = 3'd0;
        exp_locked = 1'b0;
        exp_fd     = 1'b0;
        exp_err    = 1'b0;
    endtask

    task automatic model_bit(input logic b, input logic fs);
        int slot;
        if (!m_lock) begin
            if (fs) begin
                m_lock = 1'b1;
                m_acc  = {m_acc[W-2:0], b};
                m_pos  = 1;
            end
        end else if (fs && m_pos != 0) begin
            exp_err = 1'b1;
            m_acc   = {m_acc[W-2:0], b};
            m_pos   = 1;
        end else if (!fs && m_pos == 0) begin
            exp_err = 1'b1;
            m_lock  = 1'b0;
        end else begin
            m_acc = {m_acc[W-2:0], b};
            m_pos = m_pos + 1;
            if (m_pos % W == 0) begin
                slot      = m_pos / W - 1;
                exp_data  = m_acc;
                exp_chan  = 3'(slot);
                exp_valid = chan_en[slot] ? (8'd1 << slot) : 8'd0;
                exp_fd    = (slot == 7);
                if (m_pos == FRAME) m_pos = 0;
            end
        end
        exp_locked = m_lock;
        exp_s      = m_lock ? 3'(m_pos / W) : 3'd0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".s"},          32'(s),          32'(exp_s));
        chk({tag, ".out_data"},   32'(out_data),   32'(exp_data));
        chk({tag, ".out_valid"},  32'(out_valid),  32'(exp_valid));
        chk({tag, ".out_chan"},   32'(out_chan),   32'(exp_chan));
        chk({tag, ".locked"},     32'(locked),     32'(exp_locked));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(exp_fd));
        chk({tag, ".sync_err"},   32'(sync_err),   32'(exp_err));
    endtask

    // One clock: drive at negedge, predict, sample 1 time unit after posedge.
    task automatic step(input string tag, input logic v, input logic b, input logic fs);
        @(negedge clk);
        in_valid   = v;
        in_bit     = b;
        frame_sync = fs;
        exp_valid  = 8'd0;
        exp_fd     = 1'b0;
        exp_err    = 1'b0;
        if (v) model_bit(b, fs);
        @(posedge clk);
        #1;
        cyc++;
        check_all(tag);
        if (out_valid != 8'd0) begin
            n_strobe++;
            if (spacing_on && last_strobe_cyc >= 0)
                chk({tag, ".spacing"}, 32'(cyc - last_strobe_cyc), 32'(2 * W));
            last_strobe_cyc = cyc;
        end
        if (frame_done) n_fd++;
        if (sync_err) n_err++;
    endtask

    // Sends the 8 words of frame_w; sync asserted at bit positions sa / sb.
    // stall: 0 none, 1 one idle cycle before every bit, 2 random idles.
    task automatic send_frame(input string tag, input int sa, input int sb, input int stall);
        for (int k = 0; k < 8; k++) begin
            for (int i = W - 1; i >= 0; i--) begin
                int p;
                p = k * W + (W - 1 - i);
                if (stall == 1 || (stall == 2 && $urandom_range(0, 2) == 0))
                    step({tag, ".idle"}, 1'b0, 1'($urandom), 1'($urandom));
                step(tag, 1'b1, frame_w[k][i], (p == sa) || (p == sb));
            end
        end
    endtask

    task automatic clear_counts();
        n_strobe        = 0;
        n_fd            = 0;
        n_err           = 0;
        last_strobe_cyc = -1;
    endtask

    task automatic load_pattern();
        for (int k = 0; k < 8; k++) frame_w[k] = W'(8'hA0 + k);
    endtask

    task automatic load_random();
        for (int k = 0; k < 8; k++) frame_w[k] = W'($urandom);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_bit     = 1'b0;
        frame_sync = 1'b0;
        chan_en    = 8'hFF;
        cyc        = 0;
        spacing_on = 1'b0;
        clear_counts();
        model_reset();

        // Reset state
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Unsynchronised bits are ignored while hunting
        for (int i = 0; i < 12; i++) step("hunt", 1'b1, 1'($urandom), 1'b0);

        // Lock and a full frame, all channels enabled
        load_pattern();
        chan_en = 8'hFF;
        clear_counts();
        send_frame("lock", 0, -1, 0);
        chk("lock.strobes", 32'(n_strobe), 32'd8);
        chk("lock.frame_done", 32'(n_fd), 32'd1);
        chk("lock.sync_err", 32'(n_err), 32'd0);

        // Disabled channels still counted
        chan_en = 8'h55;
        clear_counts();
        send_frame("chen55", 0, -1, 0);
        chk("chen55.strobes", 32'(n_strobe), 32'd4);
        chk("chen55.frame_done", 32'(n_fd), 32'd1);

        // Early sync on bit 3 of slot 5
        chan_en = 8'hFF;
        load_random();
        clear_counts();
        send_frame("early", 0, 5 * W + 3, 0);
        chk("early.sync_err", 32'(n_err), 32'd1);
        chk("early.locked", 32'(locked), 32'd1);
        load_random();
        send_frame("realign", 0, -1, 0);

        // Missing sync at start of frame, then relock
        load_random();
        send_frame("aligned", 0, -1, 0);
        clear_counts();
        send_frame("nosync", -1, -1, 0);
        chk("nosync.strobes", 32'(n_strobe), 32'd0);
        chk("nosync.sync_err", 32'(n_err), 32'd1);
        chk("nosync.locked", 32'(locked), 32'd0);
        load_random();
        clear_counts();
        send_frame("relock", 0, -1, 0);
        chk("relock.strobes", 32'(n_strobe), 32'd8);

        // Alternating stalls: strobes every 2*W cycles
        load_pattern();
        clear_counts();
        spacing_on = 1'b1;
        send_frame("stall", 0, -1, 1);
        spacing_on = 1'b0;
        chk("stall.strobes", 32'(n_strobe), 32'd8);
        chk("stall.sync_err", 32'(n_err), 32'd0);
        load_random();
        send_frame("rstall", 0, -1, 2);

        // Asynchronous reset in the middle of slot 3
        load_pattern();
        step("mid", 1'b1, frame_w[0][W-1], 1'b1);
        for (int i = 1; i < 3 * W + 4; i++)
            step("mid", 1'b1, frame_w[i / W][W - 1 - (i % W)], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step("post_rst", 1'b1, 1'($urandom), 1'b0);
        load_random();
        send_frame("post_rst_lock", 0, -1, 0);

        // Randomized traffic: stalls, enables, occasional sync faults
        for (int i = 0; i < 1500; i++) begin
            logic v;
            logic fs;
            if (i % 64 == 0) chan_en = 8'($urandom);
            v = ($urandom_range(0, 3) != 0);
            if (m_lock && m_pos == 0)
                fs = ($urandom_range(0, 9) != 0);
            else
                fs = ($urandom_range(0, 99) < 2);
            step("rand", v, 1'($urandom), fs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux_ctrl.md
# tdm_demux_ctrl

Time-division demultiplex controller for a bit-serial link carrying 8 channel slots per frame. It locks to a frame-sync marker, counts bits and slots, and drives the 3-bit slot select for the 1-to-8 channel fan-out. Each completed slot word is delivered as a parallel word with a one-hot per-channel valid strobe. The block sits between the serial receive front end and the eight per-channel consumers, and replaces a free-running select with a frame-aligned, error-checked sequence.

## Interface
- W, 8, bits per slot word (W ≥ 2); frame length = 8·W valid bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  serial bit qualifier; nothing advances when low
- in_bit  in  1  serial data, MSB of each slot word first
- frame_sync  in  1  marks the current valid bit as bit 0 of slot 0; ignored when in_valid=0
- chan_en  in  8  per-channel enable, sampled on a word's last bit
- s  out  3  current slot index (registered); drives the fan-out select
- out_data  out  W  last completed slot word (registered; holds until the next word)
- out_valid  out  8  one-hot strobe for channel s_done, high for 1 cycle
- out_chan  out  3  slot index of out_data
- locked  out  1  high in LOCK state
- frame_done  out  1  1-cycle pulse with slot 7's word (pulses even if chan_en[7]=0)
- sync_err  out  1  1-cycle pulse on a sync violation

## Operation
- States: HUNT (reset state) and LOCK.
- HUNT:
  - Valid bits without frame_sync are discarded.
  - A valid bit with frame_sync is taken as slot 0, bit 0: shift it in, set bit_cnt=1, s=0, go to LOCK.
- LOCK, on each valid bit:
  - Shift register: sh ← {sh[W-2:0], in_bit}. bit_cnt increments.
  - On bit_cnt = W-1 (last bit):
    - out_data ← {sh[W-2:0], in_bit}; out_chan ← s.
    - out_valid[s] ← chan_en[s]; all other out_valid bits ← 0.
    - frame_done ← (s = 7).
    - bit_cnt ← 0; s ← s+1 mod 8, so slot 7 wraps to slot 0.
- Sync checks in LOCK:
  - frame_sync on bit 0 of slot 0: expected; no error.
  - frame_sync at any other position: pulse sync_err and drop the partial word (no out_valid). Re-align so this bit is slot 0, bit 0 (s=0, bit_cnt=1), and stay in LOCK.
  - Bit 0 of slot 0 without frame_sync: pulse sync_err, discard the bit, and go to HUNT with s=0.
- The frame_sync check takes priority over word completion. A sync on a last-bit position is a violation; that word is dropped.
- in_valid=0: no state change. Strobes are not regenerated and frame position is kept indefinitely.
- chan_en changes affect only words that complete after the change. A disabled channel's slot is still counted.

## Timing
- Reset values (async, immediate): s=0, out_data=0, out_valid=0, out_chan=0, locked=0, frame_done=0, sync_err=0, state=HUNT, bit_cnt=0, sh=0.
- Reset mid-frame discards all progress; the next frame_sync is needed to relock.
- Latency: the last bit is sampled at edge N. out_data, out_valid, out_chan and frame_done are valid after edge N for exactly one cycle; out_data then holds.
- s changes after edge N to the next slot. It equals the slot being received at all other times.
- sync_err is asserted after the edge that sampled the violating bit, for one cycle.
- locked rises after the edge that samples the first frame_sync bit and falls after the edge that detects a missing sync.
- Throughput: one bit per cycle while in_valid=1. Back-to-back words produce strobes exactly W cycles apart.

## Test plan
- Reset then lock, W=8: frame_sync with the first bit, 64 continuous bits, slot k word = 8'hA0+k, chan_en=8'hFF.
  - out_valid = 8'h01, 8'h02, … 8'h80 every 8 cycles; out_data = A0…A7; frame_done with A7; s wraps to 0; sync_err never.
- Disabled channels: chan_en=8'h55, same frame.
  - Strobes only for slots 0, 2, 4, 6 (data A0, A2, A4, A6); frame_done still pulses at slot 7; s still sequences 0..7.
- Early sync: frame_sync on bit 3 of slot 5.
  - sync_err 1 cycle; no strobe for slot 5; next word completes 7 valid bits later as slot 0; locked stays 1.
- Missing sync: the second frame starts without frame_sync.
  - sync_err 1 cycle; locked→0; no strobes until the next frame_sync; relock then recovers slot 0 = correct data.
- Stalls: in_valid toggling 1010… through a full frame.
  - Same 8 words and order as the continuous case; strobes at 16-cycle spacing; no sync_err.
- Async reset asserted mid-slot 3 (between edges).
  - All outputs 0 immediately; after release, bits are ignored until frame_sync.
